mux8_rr_tx: RTL
===============

# mux8_rr_tx

Eight-channel round-robin multiplexer that merges eight requester streams onto one registered output, tagging each word with its 3-bit source select code {s2,s1,s0}. It is the transmit end of the 1:8 demux path. Its out_data/out_sel pair drives a downstream demux8, which routes each word back to output d[out_sel]. Arbitration is fair round-robin, and a valid/ready handshake on the output provides backpressure.

## Interface
- DATA_W, 1: width of each channel word and of out_data.
- clk  in  1: single clock, all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_req  in  8: per-channel request; bit i set = channel i has a word pending.
- in_data  in  8*DATA_W: channel i word at bits [i*DATA_W +: DATA_W].
- in_ack  out  8: one-hot, combinational; bit i high = channel i word consumed at this clock edge.
- out_valid  out  1: out_data/out_sel hold a word.
- out_ready  in  1: downstream accepts the word this cycle.
- out_data  out  DATA_W: registered selected word.
- out_sel  out  3: registered source channel index; bit 2 = s2, bit 1 = s1, bit 0 = s0.

## Operation
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ack=0 while rst is high.
- Load condition: load = (!out_valid || out_ready) && (in_req != 0).
- Winner: the first set in_req bit when scanning ptr, ptr+1, … ptr+7, modulo 8.
- On load at the clock edge:
  - out_data ← winner's word.
  - out_sel ← winner index.
  - out_valid ← 1.
  - ptr ← (winner+1) mod 8; the 3-bit pointer wraps 7→0.
  - in_ack[winner]=1 during that cycle; all other in_ack bits are 0.
- Drain without refill: out_valid && out_ready && in_req==0 → out_valid←0. out_data and out_sel hold their last values.
- Stall: out_valid && !out_ready → all registers hold, in_ack=0, ptr unchanged, even if in_req changes.
- Requesters hold in_req and in_data stable until acked. Dropping in_req before ack is legal; that channel is simply not considered.
- Sustained throughput is one word per cycle when out_ready is held high.

## Timing
- Latency from in_req asserted with the output free to out_valid: 1 cycle. The word appears the cycle after the in_ack pulse.
- Simultaneous drain and refill (out_valid && out_ready && in_req!=0): the new word replaces the old one at the same edge with no bubble.
- All eight channels requesting continuously: grants rotate 0,1,…,7,0,… and each channel is served exactly once per 8 loads.
- Single requester i held high: granted on every load; ptr stays at i+1.
- Reset asserted mid-stream: the output is cleared immediately and any in-flight word is lost.
  - First load after reset release starts the scan from channel 0.
- out_data, out_sel and out_valid are purely registered. in_ack is the only combinational output.
  - in_ack depends on in_req, out_valid, out_ready and ptr.

## Structure
- Package mux8_pkg holds:
  - NUM_CH=8.
  - SEL_W=3.
  - Function next_ptr(idx), implementing (idx+1) mod NUM_CH.
- Sub-module rr_arbiter8, purely combinational:
  - Inputs: req[7:0], ptr[2:0], en.
  - Outputs: gnt[7:0] (one-hot) and gnt_idx[2:0].
  - Top level holds ptr and the output register, and drives en=load-free condition.
- in_ack = gnt & {8{load}}.

## Test plan
- Reset: assert rst with in_req=8'hFF → out_valid=0, out_sel=0, out_data=0, in_ack=0. Release rst with out_ready=1 → next edge out_sel=0, then 1,2,…,7,0 on consecutive cycles.
- Single channel: DATA_W=1, in_req=8'b0000_0100, in_data bit2=1, out_ready=1 → in_ack=8'h04 every cycle; out_sel=3'b010 and out_data=1 from cycle 1. Downstream demux8 drives only d2 high.
- Fairness: in_req=8'b1000_0001 continuously → out_sel alternates 0,7,0,7. ptr wrap 7→0 verified.
- Backpressure: out_valid=1 with out_sel=3, out_ready=0 for 5 cycles while in_req changes → outputs frozen, in_ack=0. First cycle with out_ready=1 → refill with no bubble.
- Drain: last requester acked, then in_req=0, out_ready=1 → out_valid falls the next cycle; out_sel and out_data hold.
- Async reset mid-stream: rst pulsed between clock edges → out_valid drops before the next edge. Post-reset scan starts at channel 0 even though ptr was 5.

Source files
------------

// File: rtl/mux8_pkg.sv
// Shared constants and helpers for the eight-channel round-robin transmit mux.
package mux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    // Pointer advance; the 3-bit width makes the wrap 7->0 implicit.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin arbiter: grants the first request found scanning
// upward from ptr, wrapping modulo eight.
module rr_arbiter8
    import mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + SEL_W'(k);
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_tx.sv
// Eight-to-one round-robin transmit mux: registers the granted word together
// with its source index behind a valid/ready output handshake.
module mux8_rr_tx
    import mux8_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_req,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel
);

    logic [SEL_W-1:0]  ptr;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              slot_free;
    logic              load;
    logic [DATA_W-1:0] win_data;

    assign slot_free = !out_valid || out_ready;
    assign load      = slot_free && (in_req != '0);
    assign win_data  = in_data[gnt_idx*DATA_W +: DATA_W];

    // Held low during reset so no requester sees a consume that never lands.
    assign in_ack    = gnt & {NUM_CH{load && !rst}};

    rr_arbiter8 u_arb (
        .req     (in_req),
        .ptr     (ptr),
        .en      (slot_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= gnt_idx;
            ptr       <= next_ptr(gnt_idx);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
